axil_csr_master: RTL
====================

AXIL_CSR_MASTER -- requirements
Module: axil_csr_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, AXI-Lite address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, handshake timeout limit; legal range 1..65535.
REQ-003 SHALL have aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have the command inputs cmd_valid (1), cmd_write (1), cmd_addr (ADDR_W) and cmd_wdata (32), plus the output cmd_ready (1): the request channel.
REQ-006 SHALL have the response outputs rsp_valid (1), rsp_rdata (32), rsp_resp (2) and rsp_timeout (1), plus the input rsp_ready (1): the completion channel.
REQ-007 SHALL have the AXI-Lite master ports:
- outputs m_axi_awaddr/awprot/awvalid, wdata/wstrb/wvalid, bready, araddr/arprot/arvalid, rready;
- inputs awready, wready, bresp/bvalid, arready, rdata/rresp/rvalid;
- widths: address ADDR_W, data 32, wstrb 4, prot 3, resp 2.

Function
REQ-008 SHALL implement the FSM states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA and RSP.
REQ-009 SHALL drive cmd_ready high only in IDLE; cmd_valid&&cmd_ready registers cmd_addr and cmd_wdata and moves to WR if cmd_write=1, else to RD_ADDR.
REQ-010 SHALL, on entering WR, assert awvalid and wvalid in the same cycle, with wstrb=4'b1111 and awprot=arprot=3'b000.
REQ-011 SHALL track AW and W completion independently:
- awvalid drops on the cycle after awready&&awvalid;
- wvalid drops on the cycle after wready&&wvalid;
- the handshakes may occur in either order or in the same cycle;
- the FSM moves to WR_RESP once both are done.
REQ-012 SHALL hold bready high in WR_RESP; bvalid&&bready captures bresp into rsp_resp, sets rsp_rdata=0 and moves to RSP.
REQ-013 SHALL hold arvalid in RD_ADDR until arready, then move to RD_DATA.
REQ-014 SHALL hold rready high in RD_DATA; rvalid&&rready captures rdata and rresp and moves to RSP.
REQ-015 SHALL hold rsp_valid high in RSP with stable payload until rsp_ready, then return to IDLE.
- Minimum command-to-response latency is 3 cycles for reads and 3 cycles for writes when the slave readies immediately.
REQ-016 SHALL never have more than one transaction outstanding; AW/W and AR are never asserted together.
REQ-017 SHALL keep address, data and strobe stable while the associated valid is high.

Reset
REQ-018 SHALL, while aresetn=0, asynchronously force:
- state=IDLE;
- all valid and ready outputs 0, except cmd_ready=1 after reset release;
- rsp_rdata=0, rsp_resp=0, rsp_timeout=0, and all address and data outputs 0.
REQ-019 SHALL abandon any in-flight transaction on reset mid-operation, with no response produced for it.

Configuration
REQ-020 SHALL include a timeout watchdog when AXIL_CSR_MASTER_TIMEOUT_EN is defined:
- a 16-bit counter clears on each state entry and increments in WR, WR_RESP, RD_ADDR and RD_DATA;
- when it reaches TIMEOUT_CYCLES, all AXI valids and readies drop next cycle;
- the FSM then goes to RSP with rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0.
REQ-021 SHALL, without AXIL_CSR_MASTER_TIMEOUT_EN, have no counter logic, wait indefinitely, and tie rsp_timeout to 0.

Structure
REQ-022 SHALL take from shared package axil_pkg:
- the FSM state enum typedef;
- the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
- the constant WSTRB_FULL=4'b1111.
REQ-023 SHALL place the watchdog in sub-module axil_timeout_ctr (inputs clear/run, output expired), instantiated only under the macro.

Verification
REQ-024 SHALL cover: write addr 0x08 data 0x0000_0003, with awready and wready both high on the first valid cycle, then bvalid with bresp=0 -> bready seen, rsp_valid with rsp_resp=0, total 3 cycles.
REQ-025 SHALL cover: write with wready 2 cycles before awready -> wvalid drops after its handshake, awvalid held, then exactly one B handshake and one response.
REQ-026 SHALL cover: read addr 0x3C, arready after 4 cycles, rdata=0x0000_4000 -> rsp_rdata=0x0000_4000, rsp_resp=0.
REQ-027 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid and payload stable and cmd_ready low until acceptance.
REQ-028 SHALL cover: with the macro on and TIMEOUT_CYCLES=16, an unresponsive slave -> abort after 16 cycles, rsp_resp=2'b10 and rsp_timeout=1; with the macro off -> still waiting at cycle 1000.
REQ-029 SHALL cover: aresetn asserted low while in WR_RESP -> outputs reach reset values immediately, no rsp_valid, and the next command completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axil_pkg : shared FSM state type and AXI-Lite constants            |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } axil_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] WSTRB_FULL  = 4'b1111;
  localparam logic [2:0] PROT_NONE   = 3'b000;

endpackage
`default_nettype wire

// File: rtl/axil_timeout_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axil_timeout_ctr : 16-bit handshake watchdog, saturates at LIMIT   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module axil_timeout_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [15:0] LIMIT_C = 16'(LIMIT);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (run && !expired) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LIMIT_C);

endmodule
`default_nettype wire

// File: rtl/axil_csr_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axil_csr_master : single-outstanding AXI-Lite CSR access master    |
// | optional watchdog: AXIL_CSR_MASTER_TIMEOUT_EN            rev 1.0   |
// +--------------------------------------------------------------------+
module axil_csr_master
  import axil_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  axil_state_t       state, state_nx;
  logic              aw_done, w_done;
  logic              busy, expired, timed_out;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_awprot = PROT_NONE;
  assign m_axi_arprot = PROT_NONE;

  always_comb begin
    state_nx      = state;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wstrb   = 4'b0000;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    busy          = 1'b0;
    timed_out     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = aresetn;
        if (cmd_valid) state_nx = cmd_write ? WR : RD_ADDR;
      end
      WR: begin
        busy          = 1'b1;
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        m_axi_wstrb   = w_done ? 4'b0000 : WSTRB_FULL;
        // A handshake landing in the expiry cycle still wins over the abort.
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) begin
          state_nx = WR_RESP;
        end else if (expired) begin
          state_nx  = RSP;
          timed_out = 1'b1;
        end
      end
      WR_RESP: begin
        busy         = 1'b1;
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          state_nx = RSP;
        end else if (expired) begin
          state_nx  = RSP;
          timed_out = 1'b1;
        end
      end
      RD_ADDR: begin
        busy          = 1'b1;
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_nx = RD_DATA;
        end else if (expired) begin
          state_nx  = RSP;
          timed_out = 1'b1;
        end
      end
      RD_DATA: begin
        busy         = 1'b1;
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          state_nx = RSP;
        end else if (expired) begin
          state_nx  = RSP;
          timed_out = 1'b1;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_resp  <= RESP_OKAY;
    end else begin
      state   <= state_nx;
      aw_done <= (state == WR) && (state_nx == WR) && (aw_done || m_axi_awready);
      w_done  <= (state == WR) && (state_nx == WR) && (w_done || m_axi_wready);
      if (state == IDLE && cmd_valid) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      if (timed_out) begin
        rsp_rdata <= 32'd0;
        rsp_resp  <= RESP_SLVERR;
      end else if (state == WR_RESP && m_axi_bvalid) begin
        rsp_rdata <= 32'd0;
        rsp_resp  <= m_axi_bresp;
      end else if (state == RD_DATA && m_axi_rvalid) begin
        rsp_rdata <= m_axi_rdata;
        rsp_resp  <= m_axi_rresp;
      end
    end
  end

`ifdef AXIL_CSR_MASTER_TIMEOUT_EN
  axil_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (aclk),
    .rst_n   (aresetn),
    .clear   (state_nx != state),
    .run     (busy),
    .expired (expired)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_timeout <= 1'b0;
    end else if (timed_out) begin
      rsp_timeout <= 1'b1;
    end else if (state == IDLE && cmd_valid) begin
      rsp_timeout <= 1'b0;
    end
  end
`else
  logic unused_cfg;
  assign expired     = 1'b0;
  assign rsp_timeout = 1'b0;
  assign unused_cfg  = ^{busy, 16'(TIMEOUT_CYCLES)};
`endif

endmodule
`default_nettype wire
